traffic_phase_scheduler: RTL and testbench

// Demand-driven phase sequencer for a two-road intersection (road 1 = main, road 2 = side).

---
 rtl/traffic_phase_scheduler.sv | 153 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Demand-driven phase sequencer for a two-road intersection (road 1 = main,
//   road 2 = side). Divides clk into whole seconds, rests in main-road green and
//   serves the side road only after a vehicle or pedestrian request, with all-red
//   clearance between phases. Lamps are registered and track the state.
//
//   Optional feature: define TRAFFIC_PREEMPT_EN to add the emergency preempt input.
//
// Ports
//   clk              system clock (CLK_HZ cycles per second)
//   reset_n          asynchronous active-low reset, forces main-road green
//   sensor2          side-road vehicle present (level)
//   ped_btn          side-road pedestrian request (pulse or level)
//   preempt          emergency preempt (TRAFFIC_PREEMPT_EN only)
//   r1,y1,g1         road-1 lamps
//   r2,y2,g2         road-2 lamps
//   phase[2:0]       current state code
//   sec_tick         one-cycle pulse on each prescaler wrap
//
// state | meaning
// ------+------------------------------------------
// G1    | main green, side red (rest state)
// Y1    | main yellow, side red
// AR1   | all red, clearing main before side green
// G2    | side green, main red
// Y2    | side yellow, main red
// AR2   | all red, clearing side before main green

module traffic_phase_scheduler #(
  parameter int CLK_HZ    = 1000000,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW    = 5,
  parameter int ALL_RED   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor2,
  input  logic       ped_btn,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic       preempt,
`endif
  output logic       r1,
  output logic       y1,
  output logic       g1,
  output logic       r2,
  output logic       y2,
  output logic       g2,
  output logic [2:0] phase,
  output logic       sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int EW = $clog2(MAX_GREEN + 1);

  localparam logic [PW-1:0] PS_TC  = PW'(CLK_HZ - 1);
  localparam logic [EW-1:0] E_MIN  = EW'(MIN_GREEN);
  localparam logic [EW-1:0] E_MAX  = EW'(MAX_GREEN);
  localparam logic [EW-1:0] E_YEL  = EW'(YELLOW);
  localparam logic [EW-1:0] E_AR   = EW'(ALL_RED);

  // lamp vector order: {r1, y1, g1, r2, y2, g2}
  localparam logic [5:0] L_G1  = 6'b001_100;
  localparam logic [5:0] L_Y1  = 6'b010_100;
  localparam logic [5:0] L_AR  = 6'b100_100;
  localparam logic [5:0] L_G2  = 6'b100_001;
  localparam logic [5:0] L_Y2  = 6'b100_010;

  typedef enum logic [2:0] {
    S_G1  = 3'd0,
    S_Y1  = 3'd1,
    S_AR1 = 3'd2,
    S_G2  = 3'd3,
    S_Y2  = 3'd4,
    S_AR2 = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] prescaler;
  logic [EW-1:0] elapsed, elapsed_inc;
  logic          req2;
  logic          preempt_i;
  logic [5:0]    lamps, lamps_nxt;

`ifdef TRAFFIC_PREEMPT_EN
  assign preempt_i = preempt;
`else
  assign preempt_i = 1'b0;
`endif

  assign sec_tick = (prescaler == PS_TC);

  // Value elapsed takes after this cycle; comparing against it lets a phase
  // end on the very tick that completes its Nth second.
  assign elapsed_inc = (sec_tick && (elapsed != E_MAX)) ? elapsed + EW'(1) : elapsed;

  always_comb begin
    state_nxt = state;
    case (state)
      S_G1:  if (!preempt_i && req2 && (elapsed_inc >= E_MIN)) state_nxt = S_Y1;
      S_Y1:  if (sec_tick && (elapsed_inc == E_YEL)) state_nxt = S_AR1;
      S_AR1: if (sec_tick && (elapsed_inc == E_AR)) state_nxt = preempt_i ? S_G1 : S_G2;
      S_G2:  if (preempt_i || (elapsed_inc == E_MAX) ||
                 ((elapsed_inc >= E_MIN) && !sensor2)) state_nxt = S_Y2;
      S_Y2:  if (sec_tick && (elapsed_inc == E_YEL)) state_nxt = S_AR2;
      S_AR2: if (sec_tick && (elapsed_inc == E_AR)) state_nxt = S_G1;
      default: state_nxt = S_G1;
    endcase
  end

  always_comb begin
    lamps_nxt = L_G1;
    case (state_nxt)
      S_G1:    lamps_nxt = L_G1;
      S_Y1:    lamps_nxt = L_Y1;
      S_AR1:   lamps_nxt = L_AR;
      S_G2:    lamps_nxt = L_G2;
      S_Y2:    lamps_nxt = L_Y2;
      S_AR2:   lamps_nxt = L_AR;
      default: lamps_nxt = L_G1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_G1;
      prescaler <= '0;
      elapsed   <= '0;
      req2      <= 1'b0;
      lamps     <= L_G1;
    end else begin
      state <= state_nxt;
      lamps <= lamps_nxt;
      if (state_nxt != state) begin
        prescaler <= '0;
        elapsed   <= '0;
      end else begin
        prescaler <= sec_tick ? '0 : prescaler + PW'(1);
        elapsed   <= elapsed_inc;
      end
      // Entry into G2 consumes the request; a request seen on that same cycle is dropped.
      if ((state_nxt == S_G2) && (state != S_G2)) begin
        req2 <= 1'b0;
      end else if ((state != S_G2) && (sensor2 || ped_btn)) begin
        req2 <= 1'b1;
      end
    end
  end

  assign {r1, y1, g1, r2, y2, g2} = lamps;
  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  logic       clk;
  logic       reset_n;
  logic       sensor2;
  logic       ped_btn;
`ifdef TRAFFIC_PREEMPT_EN
  logic       preempt;
`endif
  logic       r1, y1, g1, r2, y2, g2;
  logic [2:0] phase;
  logic       sec_tick;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_phase_scheduler #(
    .CLK_HZ(4), .MIN_GREEN(3), .MAX_GREEN(6), .YELLOW(2), .ALL_RED(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sensor2(sensor2),
    .ped_btn(ped_btn),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt(preempt),
`endif
    .r1(r1), .y1(y1), .g1(g1),
    .r2(r2), .y2(y2), .g2(g2),
    .phase(phase),
    .sec_tick(sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int want);
    n_tests++;
    if (obs != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // {r1,y1,g1,r2,y2,g2} for each phase code
  function automatic int lamps_for(input int ph);
    case (ph)
      0: return 6'b001_100;
      1: return 6'b010_100;
      2: return 6'b100_100;
      3: return 6'b100_001;
      4: return 6'b100_010;
      5: return 6'b100_100;
      default: return 0;
    endcase
  endfunction

  function automatic int lamps_now();
    return int'({r1, y1, g1, r2, y2, g2});
  endfunction

  // Schedule for ped pulse at 2, then sensor2 held from 48 to 95.
  function automatic int exp_t23(input int c);
    if (c < 12)  return 0;
    if (c < 20)  return 1;
    if (c < 24)  return 2;
    if (c < 36)  return 3;
    if (c < 44)  return 4;
    if (c < 48)  return 5;
    if (c < 60)  return 0;
    if (c < 68)  return 1;
    if (c < 72)  return 2;
    if (c < 96)  return 3;
    if (c < 104) return 4;
    if (c < 108) return 5;
    return 0;
  endfunction

  // Schedule for button at 40 with an idle, saturated G1.
  function automatic int exp_t4(input int c);
    if (c < 42) return 0;
    if (c < 50) return 1;
    if (c < 54) return 2;
    if (c < 66) return 3;
    return 4;
  endfunction

  // Cycle 0 is the cycle right after reset release; inputs are driven and
  // outputs sampled at the falling edge preceding each cycle's rising edge.
  task automatic do_reset();
    reset_n = 1'b0;
    sensor2 = 1'b0;
    ped_btn = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
    preempt = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Test 1: idle after reset
    check("rst_phase", int'(phase), 0);
    check("rst_lamps", lamps_now(), lamps_for(0));
    check("rst_tick", int'(sec_tick), 0);
    check("rst_req2", int'(dut.req2), 0);
    for (int c = 0; c < 200; c++) begin
      check("idle_phase", int'(phase), 0);
      check("idle_lamps", lamps_now(), lamps_for(0));
      check("idle_tick", int'(sec_tick), (c % 4 == 3) ? 1 : 0);
      @(negedge clk);
    end

    // Tests 2/3: ped pulse cycle, then sensor2 held through G2 (max green)
    do_reset();
    for (int c = 0; c < 130; c++) begin
      ped_btn = (c == 2);
      sensor2 = (c >= 48 && c < 96);
      check("seq_phase", int'(phase), exp_t23(c));
      check("seq_lamps", lamps_now(), lamps_for(exp_t23(c)));
      check("seq_tick", int'(sec_tick), (c % 4 == 3) ? 1 : 0);
      if (c == 2)   check("req2_before", int'(dut.req2), 0);
      if (c == 3)   check("req2_set", int'(dut.req2), 1);
      if (c == 24)  check("req2_clr_g2", int'(dut.req2), 0);
      if (c == 72)  check("req2_clr_wins", int'(dut.req2), 0);
      if (c == 120) check("req2_idle", int'(dut.req2), 0);
      @(negedge clk);
    end
    ped_btn = 1'b0;
    sensor2 = 1'b0;

    // Test 4: late demand, then Test 5: reset mid-Y2
    do_reset();
    for (int c = 0; c <= 70; c++) begin
      ped_btn = (c == 40);
      check("late_phase", int'(phase), exp_t4(c));
      check("late_lamps", lamps_now(), lamps_for(exp_t4(c)));
      if (c == 40) check("late_req2_pre", int'(dut.req2), 0);
      if (c == 41) check("late_req2", int'(dut.req2), 1);
      if (c == 54) check("late_req2_g2", int'(dut.req2), 0);
      if (c < 70) @(negedge clk);
    end
    ped_btn = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_phase", int'(phase), 0);
    check("async_lamps", lamps_now(), lamps_for(0));
    check("async_tick", int'(sec_tick), 0);
    check("async_req2", int'(dut.req2), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      ped_btn = (c == 2);
      check("resume_phase", int'(phase), (c < 12) ? 0 : 1);
      check("resume_tick", int'(sec_tick), (c % 4 == 3) ? 1 : 0);
      @(negedge clk);
    end
    ped_btn = 1'b0;

`ifdef TRAFFIC_PREEMPT_EN
    // Test 6: preempt 1 s into G2; G1 holds while preempt stays high
    do_reset();
    for (int c = 0; c < 63; c++) begin
      int e;
      ped_btn = (c == 2 || c == 30);
      preempt = (c >= 28 && c < 60);
      if (c < 12)      e = 0;
      else if (c < 20) e = 1;
      else if (c < 24) e = 2;
      else if (c < 29) e = 3;
      else if (c < 37) e = 4;
      else if (c < 41) e = 5;
      else if (c < 61) e = 0;
      else             e = 1;
      check("pre_phase", int'(phase), e);
      check("pre_lamps", lamps_now(), lamps_for(e));
      if (c == 45) check("pre_req2_held", int'(dut.req2), 1);
      @(negedge clk);
    end
    ped_btn = 1'b0;
    preempt = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
